// File: rtl/traffic_pkg.sv
// Shared types and constants for the main/side traffic light controller:
// state encoding, one-hot lamp patterns {red, yellow, green} and default intervals.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_EXT = 3'd4,
    SIDE_YEL = 3'd5
  } state_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam int TICKS_PER_SEC_DEF = 2;
  localparam int T_BASE_DEF        = 6;
  localparam int T_EXT_DEF         = 3;
  localparam int T_YEL_DEF         = 2;
  localparam int TW_DEF            = 4;

endpackage

// File: rtl/traffic_fsm_interval_timer.sv
// Seconds prescaler plus TW-bit interval down-counter; expire marks the
// last cycle of the loaded interval (second tick with the counter at zero).
module interval_timer #(
  parameter int TICKS_PER_SEC = 2,
  parameter int TW            = 4,
  parameter int RESET_VAL     = 5
) (
  input  logic          clk,
  input  logic          reset_sync,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          sec_tick;

  assign sec_tick = (pre_q == PRE_MAX);
  assign expire   = sec_tick && (cnt_q == '0);

  // A load restarts the second boundary so every interval is exactly T*TICKS_PER_SEC cycles.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
      pre_d = '0;
    end else if (sec_tick) begin
      pre_d = '0;
      cnt_d = cnt_q - 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      pre_q <= '0;
      cnt_q <= TW'(RESET_VAL);
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// Main/side traffic light controller with pedestrian walk phase.
// Define TRAFFIC_FSM_SENSOR_EXT_EN to enable the sensor-driven SIDE_EXT green extension.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int T_BASE        = T_BASE_DEF,
  parameter int T_EXT         = T_EXT_DEF,
  parameter int T_YEL         = T_YEL_DEF,
  parameter int TW            = TW_DEF
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       wr,
  input  logic       sensor_sync,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       walk,
  output logic       wr_reset
);

  state_e        state_q, state_d;
  logic          wr_reset_q, wr_reset_d;
  logic          expire;
  logic [TW-1:0] load_val;

  interval_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .TW            (TW),
    .RESET_VAL     (T_BASE - 1)
  ) u_timer (
    .clk        (clk),
    .reset_sync (reset_sync),
    .load       (expire),
    .load_val   (load_val),
    .expire     (expire)
  );

  // Inputs only matter on the expiry cycle; every expiry reloads the timer,
  // including MAIN_GRN re-entering itself.
  always_comb begin
    state_d = state_q;
    if (expire) begin
      case (state_q)
        MAIN_GRN: state_d = (wr || sensor_sync) ? MAIN_YEL : MAIN_GRN;
        MAIN_YEL: state_d = wr ? WALK : SIDE_GRN;
        WALK:     state_d = SIDE_GRN;
`ifdef TRAFFIC_FSM_SENSOR_EXT_EN
        SIDE_GRN: state_d = sensor_sync ? SIDE_EXT : SIDE_YEL;
        SIDE_EXT: state_d = SIDE_YEL;
`else
        SIDE_GRN: state_d = SIDE_YEL;
`endif
        SIDE_YEL: state_d = MAIN_GRN;
        default:  state_d = MAIN_GRN;
      endcase
    end
  end

  always_comb begin
    load_val = TW'(T_YEL - 1);
    case (state_d)
      MAIN_GRN, SIDE_GRN: load_val = TW'(T_BASE - 1);
      WALK, SIDE_EXT:     load_val = TW'(T_EXT - 1);
      default:            load_val = TW'(T_YEL - 1);
    endcase
  end

  // WALK is never re-entered from itself, so entry is the only way to set this.
  assign wr_reset_d = expire && (state_d == WALK);

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q    <= MAIN_GRN;
      wr_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_reset_q <= wr_reset_d;
    end
  end

  always_comb begin
    main_lt = LT_RED;
    side_lt = LT_RED;
    walk    = 1'b0;
    case (state_q)
      MAIN_GRN:           main_lt = LT_GRN;
      MAIN_YEL:           main_lt = LT_YEL;
      WALK:               walk    = 1'b1;
      SIDE_GRN, SIDE_EXT: side_lt = LT_GRN;
      SIDE_YEL:           side_lt = LT_YEL;
      default:            main_lt = LT_RED;
    endcase
  end

  assign wr_reset = wr_reset_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm at default parameters: phase/countdown reference model
// feeding an expected queue, scenario tasks with absolute-cycle checks, random run.
module tb_traffic_fsm;

  localparam int TPS = 2;
  localparam int TB  = 6;
  localparam int TE  = 3;
  localparam int TY  = 2;

  localparam int P_MG = 0;
  localparam int P_MY = 1;
  localparam int P_WK = 2;
  localparam int P_SG = 3;
  localparam int P_SE = 4;
  localparam int P_SY = 5;

  logic       clk = 1'b0;
  logic       reset_sync = 1'b1;
  logic       wr = 1'b0;
  logic       sensor_sync = 1'b0;
  logic [2:0] main_lt;
  logic [2:0] side_lt;
  logic       walk;
  logic       wr_reset;

  traffic_fsm dut (
    .clk         (clk),
    .reset_sync  (reset_sync),
    .wr          (wr),
    .sensor_sync (sensor_sync),
    .main_lt     (main_lt),
    .side_lt     (side_lt),
    .walk        (walk),
    .wr_reset    (wr_reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int m_ph;
  int m_rem;

  function automatic int dur(input int ph);
    case (ph)
      P_MG, P_SG: return TB * TPS;
      P_WK, P_SE: return TE * TPS;
      default:    return TY * TPS;
    endcase
  endfunction

  // {main[2:0], side[2:0], walk, wr_reset}
  function automatic logic [7:0] lights(input int ph, input bit first);
    case (ph)
      P_MG:    return 8'b001_100_0_0;
      P_MY:    return 8'b010_100_0_0;
      P_WK:    return {6'b100_100, 1'b1, first};
      P_SG:    return 8'b100_001_0_0;
      P_SE:    return 8'b100_001_0_0;
      default: return 8'b100_010_0_0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph  = P_MG;
    m_rem = dur(P_MG);
    exp_q.delete();
    exp_q.push_back(lights(P_MG, 1'b0));
  endtask

  task automatic model_step(input bit w, input bit s);
    int nxt;
    bit first;
    first = 1'b0;
    if (m_rem == 1) begin
      case (m_ph)
        P_MG: nxt = (w || s) ? P_MY : P_MG;
        P_MY: nxt = w ? P_WK : P_SG;
        P_WK: nxt = P_SG;
`ifdef TRAFFIC_FSM_SENSOR_EXT_EN
        P_SG: nxt = s ? P_SE : P_SY;
`else
        P_SG: nxt = P_SY;
`endif
        P_SE: nxt = P_SY;
        default: nxt = P_MG;
      endcase
      first = (nxt == P_WK);
      m_ph  = nxt;
      m_rem = dur(nxt);
    end else begin
      m_rem = m_rem - 1;
    end
    exp_q.push_back(lights(m_ph, first));
  endtask

  task automatic clock_cycle(input bit w, input bit s);
    wr = w;
    sensor_sync = s;
    model_step(w, s);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    wr = 1'b0;
    sensor_sync = 1'b0;
    reset_sync = 1'b1;
    @(posedge clk);
    #1;
    reset_sync = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({main_lt, side_lt, walk, wr_reset} !== 8'b001_100_0_0)
      $display("FAIL reset_values got %b expected %b", {main_lt, side_lt, walk, wr_reset}, 8'b001_100_0_0);
    else passed++;
    void'(exp_q.pop_front());
    exp_q.push_back(lights(P_MG, 1'b0));
  endtask

  task automatic test_idle();
    logic [7:0] e;
    int wrr_seen;
    wrr_seen = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      if (wr_reset) wrr_seen++;
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL idle cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b0, 1'b0);
    end
    checks++;
    if (wrr_seen !== 0) $display("FAIL idle_wr_reset count %0d expected 0", wrr_seen);
    else passed++;
  endtask

  task automatic test_walk();
    logic [7:0] e;
    int walk_start, sg_start, mg_back, wrr_cnt, wrr_cyc;
    walk_start = -1; sg_start = -1; mg_back = -1; wrr_cnt = 0; wrr_cyc = -1;
    apply_reset();
    for (int i = 0; i < 42; i++) begin
      e = exp_q.pop_front();
      if (walk && walk_start < 0) walk_start = cyc;
      if (side_lt == 3'b001 && sg_start < 0) sg_start = cyc;
      if (main_lt == 3'b001 && cyc > 20 && mg_back < 0) mg_back = cyc;
      if (wr_reset) begin wrr_cnt++; wrr_cyc = cyc; end
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL walk cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b1, 1'b0);
    end
    checks++;
    if (walk_start !== 16) $display("FAIL walk_start got %0d expected 16", walk_start); else passed++;
    checks++;
    if (wrr_cnt !== 1 || wrr_cyc !== 16)
      $display("FAIL wr_reset_pulse count %0d at %0d expected 1 at 16", wrr_cnt, wrr_cyc);
    else passed++;
    checks++;
    if (sg_start !== 22) $display("FAIL walk_side_grn got %0d expected 22", sg_start); else passed++;
    checks++;
    if (mg_back !== 38) $display("FAIL walk_main_back got %0d expected 38", mg_back); else passed++;
  endtask

  task automatic test_sensor();
    logic [7:0] e;
    int sg_start, sy_start, exp_sy;
`ifdef TRAFFIC_FSM_SENSOR_EXT_EN
    exp_sy = 34;
`else
    exp_sy = 28;
`endif
    sg_start = -1; sy_start = -1;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      if (side_lt == 3'b001 && sg_start < 0) sg_start = cyc;
      if (side_lt == 3'b010 && sy_start < 0) sy_start = cyc;
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL sensor cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b0, 1'b1);
    end
    checks++;
    if (sg_start !== 16) $display("FAIL sensor_side_grn got %0d expected 16", sg_start); else passed++;
    checks++;
    if (sy_start !== exp_sy) $display("FAIL sensor_side_yel got %0d expected %0d", sy_start, exp_sy); else passed++;
  endtask

  task automatic test_walk_priority();
    logic [7:0] e;
    logic walk_at16;
    walk_at16 = 1'b0;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      e = exp_q.pop_front();
      if (cyc == 16) walk_at16 = walk;
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL priority cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(cyc >= 12, 1'b1);
    end
    checks++;
    if (walk_at16 !== 1'b1) $display("FAIL walk_priority walk %b expected 1", walk_at16); else passed++;
  endtask

  task automatic test_reset_in_walk();
    logic [7:0] e;
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL rst_walk cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b1, 1'b0);
    end
    checks++;
    if (walk !== 1'b1) $display("FAIL rst_walk_in_walk walk %b expected 1", walk); else passed++;
    apply_reset();
    e = exp_q.pop_front();
    exp_q.push_back(e);
    checks++;
    if ({main_lt, side_lt, walk, wr_reset} !== 8'b001_100_0_0)
      $display("FAIL rst_walk_after got %b expected %b", {main_lt, side_lt, walk, wr_reset}, 8'b001_100_0_0);
    else passed++;
    for (int i = 0; i < 14; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL rst_walk_post cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_sensor_pulse();
    logic [7:0] e;
    logic [2:0] main_at12;
    main_at12 = 3'b000;
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      e = exp_q.pop_front();
      if (cyc == 12) main_at12 = main_lt;
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL pulse cyc %0d got %b expected %b", cyc, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      clock_cycle(1'b0, (cyc >= 3 && cyc <= 5));
    end
    checks++;
    if (main_at12 !== 3'b001) $display("FAIL pulse_reload main %b expected 001", main_at12); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] e;
    bit w_reg;
    bit s;
    w_reg = 1'b0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({main_lt, side_lt, walk, wr_reset} !== e)
        $display("FAIL random step %0d got %b expected %b", i, {main_lt, side_lt, walk, wr_reset}, e);
      else passed++;
      // Emulate the walk register: set by random button presses, cleared by the grant pulse.
      if (wr_reset) w_reg = 1'b0;
      if ($urandom_range(0, 15) == 0) w_reg = 1'b1;
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        apply_reset();
        w_reg = 1'b0;
      end else begin
        clock_cycle(w_reg, s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_walk();
    test_sensor();
    test_walk_priority();
    test_reset_in_walk();
    test_sensor_pulse();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
